// File: rtl/poly_interp_pkg.sv
// Shared types and the 21-tap prototype coefficient table
// for the polyphase interpolate-by-3 FIR.
package poly_interp_pkg;

  localparam int L      = 3;
  localparam int TPP    = 7;
  localparam int NTAP   = L * TPP;
  localparam int IN_W   = 8;
  localparam int OUT_W  = 20;
  localparam int ACC_W  = 20;
  localparam int CW     = 10;
  localparam int RND_SH = 8;

  typedef logic signed [IN_W-1:0]  samp_t;
  typedef logic signed [ACC_W-1:0] acc_t;
  typedef logic signed [CW-1:0]    coef_t;

  typedef enum logic {
    IDLE,
    EMIT
  } state_e;

  localparam coef_t H [NTAP] = '{
    -10'sd4,   -10'sd1,   10'sd4,
     10'sd9,    10'sd5,  -10'sd15,
    -10'sd36,  -10'sd22,  10'sd51,
     10'sd161,  10'sd244, 10'sd244,
     10'sd161,  10'sd51, -10'sd22,
    -10'sd36,  -10'sd15,  10'sd5,
     10'sd9,    10'sd4,  -10'sd1
  };

  // Indices past the table (phase 3) read as zero
  function automatic coef_t coef(
    input logic [4:0] i
  );
    if (i < 5'(NTAP)) coef = H[i];
    else              coef = '0;
  endfunction

endpackage

// File: rtl/poly_interp_x3_dot.sv
// Combinational 7-tap dot product for one polyphase
// branch: sum of h[3k+p] * x[k].
module poly_phase_dot
  import poly_interp_pkg::*;
(
  input  samp_t      x_i [TPP],
  input  logic [1:0] phase_i,
  output acc_t       acc_o
);

  acc_t       sum;
  acc_t       xs;
  acc_t       cs;
  logic [4:0] idx;

  always_comb begin
    sum = '0;
    xs  = '0;
    cs  = '0;
    idx = '0;
    for (int k = 0; k < TPP; k++) begin
      idx = 5'(L * k) + 5'(phase_i);
      xs  = acc_t'(x_i[k]);
      cs  = acc_t'(coef(idx));
      sum = sum + xs * cs;
    end
  end

  assign acc_o = sum;

endmodule

// File: rtl/poly_interp_x3.sv
// Polyphase interpolate-by-3 FIR, valid/ready both sides.
// Define INTERP_ROUND_EN for rounded >>>8 output (+1 stage).
module poly_interp_x3
  import poly_interp_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_phase
);

  state_e     state_q;
  logic [1:0] phase_q;
  samp_t      x_q   [TPP];
  samp_t      x_sh  [TPP];
  samp_t      dot_x [TPP];
  logic [1:0] dot_p;
  acc_t       dot_acc;
  acc_t       acc_q;
  logic       fv_q;
  logic       fadv;
  logic       rdy_q;
  logic       last_ph;
  logic       take_in;

  assign last_ph = (phase_q == 2'd2);

  assign in_ready = rdy_q &
    ((state_q == IDLE) |
     ((state_q == EMIT) & last_ph & fv_q & fadv));

  assign take_in = in_valid & in_ready;

  always_comb begin
    x_sh[0] = $signed(in_data);
    for (int k = 1; k < TPP; k++)
      x_sh[k] = x_q[k-1];
  end

  // Dot product sees the post-shift line on an input
  // accept, otherwise the next phase of the held line.
  always_comb begin
    for (int k = 0; k < TPP; k++)
      dot_x[k] = take_in ? x_sh[k] : x_q[k];
    dot_p = take_in ? 2'd0 : phase_q + 2'd1;
  end

  poly_phase_dot u_dot (
    .x_i     (dot_x),
    .phase_i (dot_p),
    .acc_o   (dot_acc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      phase_q <= '0;
      fv_q    <= 1'b0;
      acc_q   <= '0;
      rdy_q   <= 1'b0;
      for (int k = 0; k < TPP; k++)
        x_q[k] <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (take_in) begin
        for (int k = 0; k < TPP; k++)
          x_q[k] <= x_sh[k];
      end
      unique case (state_q)
        IDLE: begin
          if (take_in) begin
            state_q <= EMIT;
            phase_q <= 2'd0;
            fv_q    <= 1'b1;
            acc_q   <= dot_acc;
          end
        end
        EMIT: begin
          if (fv_q && fadv) begin
            if (!last_ph || take_in) begin
              phase_q <= dot_p;
              acc_q   <= dot_acc;
            end else begin
              state_q <= IDLE;
              phase_q <= 2'd0;
              fv_q    <= 1'b0;
            end
          end
        end
      endcase
    end
  end

`ifdef INTERP_ROUND_EN
  acc_t                    rnd;
  logic signed [OUT_W-1:0] od_q;
  logic [1:0]              op_q;
  logic                    ov_q;

  assign fadv = !ov_q | out_ready;
  assign rnd  =
    (acc_q + acc_t'(1 <<< (RND_SH - 1))) >>> RND_SH;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ov_q <= 1'b0;
      od_q <= '0;
      op_q <= '0;
    end else if (fadv) begin
      ov_q <= fv_q;
      if (fv_q) begin
        od_q <= rnd;
        op_q <= phase_q;
      end
    end
  end

  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign out_phase = op_q;
`else
  assign fadv      = out_ready;
  assign out_valid = fv_q;
  assign out_data  = acc_q;
  assign out_phase = phase_q;
`endif

endmodule
